// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive-side frame sequencer between the sync detectors and
// the depacketizer of the PSK demod chain.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   RX_BD_WINDOW     Barker search window in symbols
//   MODE_CTRL        [0] rx enable, [1] BPSK payload, [3:2] reserved
//   sym_valid        symbol strobe; every counter steps on it
//   SD_flag          signal detect level
//   PD_flag          preamble detect pulse
//   BD_flag, BD_sgn  Barker detect pulse and its polarity
//   frame_len        payload length in symbols
//   disassert        depacketizer end-of-frame
//   PD_en, BD_en     detector enables
//   depack_en        depacketizer symbol intake enable
//   is_bpsk          current symbols are BPSK
//   phase_flip       latched Barker polarity
//   frame_start      pulse on entering HEADER
//   frame_done       pulse on payload completion
//   timeout          pulse when the PD or BD search is abandoned
//   state            current state code
module rx_frame_ctrl #(
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int LEN_WIDTH        = 16,
    parameter int PD_TIMEOUT       = 1024,
    parameter int HDR_SYMS         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [3:0]                  MODE_CTRL,
    input  logic                        sym_valid,
    input  logic                        SD_flag,
    input  logic                        PD_flag,
    input  logic                        BD_flag,
    input  logic                        BD_sgn,
    input  logic [LEN_WIDTH-1:0]        frame_len,
    input  logic                        disassert,
    output logic                        PD_en,
    output logic                        BD_en,
    output logic                        depack_en,
    output logic                        is_bpsk,
    output logic                        phase_flip,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        timeout,
    output logic [2:0]                  state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SD_WAIT   = 3'd1;
    localparam logic [2:0] PD_WAIT   = 3'd2;
    localparam logic [2:0] BD_SEARCH = 3'd3;
    localparam logic [2:0] BD_ALIGN  = 3'd4;
    localparam logic [2:0] HEADER    = 3'd5;
    localparam logic [2:0] PAYLOAD   = 3'd6;

    localparam int PD_W = $clog2(PD_TIMEOUT) + 1;
    localparam logic [PD_W-1:0] PD_LAST = PD_W'(PD_TIMEOUT - 1);
    localparam logic [MAX_WINDOW_WIDTH-1:0] SPAN = MAX_WINDOW_WIDTH'(31);
    localparam logic [LEN_WIDTH-1:0] HDR_INIT = LEN_WIDTH'(HDR_SYMS);

    logic [PD_W-1:0]             pd_cnt;
    logic [MAX_WINDOW_WIDTH-1:0] win_cnt;
    logic [MAX_WINDOW_WIDTH-1:0] align_cnt;
    logic [MAX_WINDOW_WIDTH-1:0] align_init;
    logic [LEN_WIDTH-1:0]        sym_cnt;
    logic                        unused_rsvd;

    assign unused_rsvd = ^MODE_CTRL[3:2];

    // Alignment covers the rest of a 31-symbol span after the search window.
    assign align_init = (RX_BD_WINDOW > SPAN) ? '0 : SPAN - RX_BD_WINDOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            PD_en       <= 1'b0;
            BD_en       <= 1'b0;
            depack_en   <= 1'b0;
            is_bpsk     <= 1'b0;
            phase_flip  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            timeout     <= 1'b0;
            pd_cnt      <= '0;
            win_cnt     <= '0;
            align_cnt   <= '0;
            sym_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            timeout     <= 1'b0;
            if (!MODE_CTRL[0]) begin
                state      <= IDLE;
                PD_en      <= 1'b0;
                BD_en      <= 1'b0;
                depack_en  <= 1'b0;
                is_bpsk    <= 1'b0;
                phase_flip <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= SD_WAIT;
                    SD_WAIT: begin
                        if (SD_flag) begin
                            state  <= PD_WAIT;
                            PD_en  <= 1'b1;
                            pd_cnt <= '0;
                        end
                    end
                    PD_WAIT: begin
                        if (!SD_flag) begin
                            state <= SD_WAIT;
                            PD_en <= 1'b0;
                        end else if (PD_flag) begin
                            state   <= BD_SEARCH;
                            PD_en   <= 1'b0;
                            BD_en   <= 1'b1;
                            win_cnt <= RX_BD_WINDOW;
                        end else if (sym_valid) begin
                            if (pd_cnt == PD_LAST) begin
                                state   <= SD_WAIT;
                                PD_en   <= 1'b0;
                                timeout <= 1'b1;
                            end else begin
                                pd_cnt <= pd_cnt + 1'b1;
                            end
                        end
                    end
                    BD_SEARCH: begin
                        // A detect on the expiring symbol still wins.
                        if (BD_flag) begin
                            state      <= BD_ALIGN;
                            BD_en      <= 1'b0;
                            phase_flip <= BD_sgn;
                            align_cnt  <= align_init;
                        end else if (sym_valid) begin
                            if (win_cnt == '0) begin
                                state   <= PD_WAIT;
                                BD_en   <= 1'b0;
                                PD_en   <= 1'b1;
                                pd_cnt  <= '0;
                                timeout <= 1'b1;
                            end else begin
                                win_cnt <= win_cnt - 1'b1;
                            end
                        end
                    end
                    BD_ALIGN: begin
                        // Leave on the last alignment symbol, or at once
                        // when no alignment is needed.
                        if (align_cnt == '0 ||
                            (sym_valid && align_cnt == 1)) begin
                            state       <= HEADER;
                            frame_start <= 1'b1;
                            depack_en   <= 1'b1;
                            is_bpsk     <= 1'b1;
                            sym_cnt     <= HDR_INIT;
                        end else if (sym_valid) begin
                            align_cnt <= align_cnt - 1'b1;
                        end
                    end
                    HEADER: begin
                        if (sym_valid) begin
                            if (sym_cnt <= 1) begin
                                state   <= PAYLOAD;
                                sym_cnt <= frame_len;
                                is_bpsk <= MODE_CTRL[1];
                            end else begin
                                sym_cnt <= sym_cnt - 1'b1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (disassert || sym_cnt == '0 ||
                            (sym_valid && sym_cnt == 1)) begin
                            state      <= SD_WAIT;
                            frame_done <= 1'b1;
                            depack_en  <= 1'b0;
                            is_bpsk    <= 1'b0;
                            phase_flip <= 1'b0;
                        end else if (sym_valid) begin
                            sym_cnt <= sym_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        PD_en     <= 1'b0;
                        BD_en     <= 1'b0;
                        depack_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed bench for rx_frame_ctrl with a symbol-counting
// reference model and literal checks on frame timing.
module tb_rx_frame_ctrl;

    localparam int PDT = 20;
    localparam int HDR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  RX_BD_WINDOW;
    logic [3:0]  MODE_CTRL;
    logic        sym_valid;
    logic        SD_flag;
    logic        PD_flag;
    logic        BD_flag;
    logic        BD_sgn;
    logic [15:0] frame_len;
    logic        disassert;
    logic        PD_en;
    logic        BD_en;
    logic        depack_en;
    logic        is_bpsk;
    logic        phase_flip;
    logic        frame_start;
    logic        frame_done;
    logic        timeout;
    logic [2:0]  state;

    always #5 clk = ~clk;

    rx_frame_ctrl #(
        .MAX_WINDOW_WIDTH(8),
        .LEN_WIDTH(16),
        .PD_TIMEOUT(PDT),
        .HDR_SYMS(HDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RX_BD_WINDOW(RX_BD_WINDOW),
        .MODE_CTRL(MODE_CTRL),
        .sym_valid(sym_valid),
        .SD_flag(SD_flag),
        .PD_flag(PD_flag),
        .BD_flag(BD_flag),
        .BD_sgn(BD_sgn),
        .frame_len(frame_len),
        .disassert(disassert),
        .PD_en(PD_en),
        .BD_en(BD_en),
        .depack_en(depack_en),
        .is_bpsk(is_bpsk),
        .phase_flip(phase_flip),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .timeout(timeout),
        .state(state)
    );

    // Pending values for the slowly-changing inputs; applied inside cyc.
    logic        t_rst;
    logic [3:0]  t_mode;
    logic        t_sd;
    logic        t_sgn;
    logic [7:0]  t_win;
    logic [15:0] t_len;

    int tests = 0;
    int fails = 0;

    // Model: phase number plus a symbol count that rises within each phase.
    int m_ph = 0, m_cnt = 0, m_tgt = 0, m_len = 0, m_win = 0;
    int m_pf = 0, m_bpsk = 0, m_fs = 0, m_fd = 0, m_to = 0;

    int n_fs, n_fd, n_to, n_align, n_hdr, n_pay, pf_bad, k;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_fs = 0;
        m_fd = 0;
        m_to = 0;
        if (rst) begin
            m_ph = 0; m_pf = 0; m_bpsk = 0; m_cnt = 0;
        end else if (!MODE_CTRL[0]) begin
            m_ph = 0; m_pf = 0; m_bpsk = 0;
        end else begin
            case (m_ph)
                0: m_ph = 1;
                1: if (SD_flag) begin m_ph = 2; m_cnt = 0; end
                2: begin
                    if (!SD_flag) m_ph = 1;
                    else if (PD_flag) begin
                        m_ph = 3; m_cnt = 0; m_win = int'(RX_BD_WINDOW);
                    end else if (sym_valid) begin
                        m_cnt++;
                        if (m_cnt == PDT) begin m_ph = 1; m_to = 1; end
                    end
                end
                3: begin
                    if (BD_flag) begin
                        m_ph = 4; m_pf = int'(BD_sgn); m_cnt = 0;
                        m_tgt = (int'(RX_BD_WINDOW) > 31) ? 0 : 31 - int'(RX_BD_WINDOW);
                    end else if (sym_valid) begin
                        if (m_cnt == m_win) begin
                            m_ph = 2; m_to = 1; m_cnt = 0;
                        end else m_cnt++;
                    end
                end
                4: begin
                    if (sym_valid && m_cnt < m_tgt) m_cnt++;
                    if (m_cnt == m_tgt) begin
                        m_ph = 5; m_fs = 1; m_bpsk = 1; m_cnt = 0;
                    end
                end
                5: begin
                    if (sym_valid) begin
                        m_cnt++;
                        if (m_cnt == HDR) begin
                            m_ph = 6; m_cnt = 0;
                            m_len = int'(frame_len);
                            m_bpsk = int'(MODE_CTRL[1]);
                        end
                    end
                end
                6: begin
                    if (sym_valid && m_cnt < m_len) m_cnt++;
                    if (disassert || m_cnt == m_len) begin
                        m_ph = 1; m_fd = 1; m_pf = 0; m_bpsk = 0;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic compare();
        chk("state", int'(state), m_ph);
        chk("PD_en", int'(PD_en), int'(m_ph == 2));
        chk("BD_en", int'(BD_en), int'(m_ph == 3));
        chk("depack_en", int'(depack_en), int'(m_ph == 5 || m_ph == 6));
        chk("is_bpsk", int'(is_bpsk), m_bpsk);
        chk("phase_flip", int'(phase_flip), m_pf);
        chk("frame_start", int'(frame_start), m_fs);
        chk("frame_done", int'(frame_done), m_fd);
        chk("timeout", int'(timeout), m_to);
        if (frame_start) n_fs++;
        if (frame_done) n_fd++;
        if (timeout) n_to++;
    endtask

    // One clock: check outputs, apply next inputs, advance the model.
    task automatic cyc(input logic sv, input logic pd,
                       input logic bd, input logic dis);
        @(negedge clk);
        compare();
        rst = t_rst;
        MODE_CTRL = t_mode;
        SD_flag = t_sd;
        BD_sgn = t_sgn;
        RX_BD_WINDOW = t_win;
        frame_len = t_len;
        sym_valid = sv;
        PD_flag = pd;
        BD_flag = bd;
        disassert = dis;
        if (sv && state == 3'd4) n_align++;
        if (sv && state == 3'd5 && is_bpsk) n_hdr++;
        if (sv && state == 3'd6) n_pay++;
        if (state >= 3'd4 && state <= 3'd6 && !phase_flip) pf_bad++;
        model_step();
    endtask

    task automatic wait_state(input int s, input logic sv);
        int j = 0;
        while (int'(state) != s && j < 400) begin
            cyc(sv, 1'b0, 1'b0, 1'b0);
            j++;
        end
        chk("wait_state", int'(state), s);
    endtask

    initial begin
        t_rst = 1'b1; t_mode = 4'b0000; t_sd = 1'b0; t_sgn = 1'b0;
        t_win = 8'd8; t_len = 16'd100;
        rst = 1'b1; MODE_CTRL = 4'b0000; SD_flag = 1'b0; BD_sgn = 1'b0;
        RX_BD_WINDOW = 8'd8; frame_len = 16'd100;
        sym_valid = 1'b0; PD_flag = 1'b0; BD_flag = 1'b0; disassert = 1'b0;
        n_fs = 0; n_fd = 0; n_to = 0; n_align = 0; n_hdr = 0;
        n_pay = 0; pf_bad = 0;

        repeat (3) cyc(0, 0, 0, 0);
        chk("init_state", int'(state), 0);
        chk("init_outs", int'({PD_en, BD_en, depack_en, is_bpsk,
            phase_flip, frame_start, frame_done, timeout}), 0);

        // Full frame, QPSK payload, Barker polarity 1.
        t_rst = 1'b0; t_mode = 4'b0001; t_sd = 1'b1;
        wait_state(2, 0);
        cyc(0, 1, 0, 0);
        wait_state(3, 0);
        repeat (3) cyc(1, 0, 0, 0);
        t_sgn = 1'b1;
        cyc(0, 0, 1, 0);
        t_sgn = 1'b0;
        n_align = 0; n_hdr = 0; n_pay = 0; n_fs = 0; n_fd = 0; pf_bad = 0;
        k = 0;
        while (n_fd == 0 && k < 300) begin cyc(1, 0, 0, 0); k++; end
        chk("align_syms", n_align, 23);
        chk("hdr_bpsk_syms", n_hdr, 16);
        chk("payload_syms", n_pay, 100);
        chk("frame_starts", n_fs, 1);
        chk("frame_dones", n_fd, 1);
        chk("flip_dropouts", pf_bad, 0);
        chk("after_done_state", int'(state), 1);

        // PD search gives up after PDT symbols.
        wait_state(2, 0);
        n_to = 0;
        repeat (PDT) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pd_timeouts", n_to, 1);
        chk("pd_timeout_state", int'(state), 1);

        // Losing signal detect returns to SD_WAIT.
        wait_state(2, 0);
        t_sd = 1'b0;
        cyc(0, 0, 0, 0);
        t_sd = 1'b1;
        cyc(0, 0, 0, 0);
        chk("sd_drop_state", int'(state), 1);

        // No Barker within an 8-symbol window.
        wait_state(2, 0);
        cyc(0, 1, 0, 0);
        wait_state(3, 0);
        n_to = 0;
        repeat (9) cyc(1, 0, 0, 0);
        chk("no_early_timeout", n_to, 0);
        cyc(0, 0, 0, 0);
        chk("bd_timeouts", n_to, 1);
        chk("bd_timeout_state", int'(state), 2);

        // Barker on the expiring symbol wins over the timeout.
        cyc(0, 1, 0, 0);
        wait_state(3, 0);
        n_to = 0;
        repeat (8) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("coincide_state", int'(state), 4);
        chk("coincide_timeouts", n_to, 0);

        // BPSK payload cut short by disassert on symbol 40.
        t_mode = 4'b0011;
        n_pay = 0; n_fd = 0; k = 0;
        while (state != 3'd6 && k < 100) begin cyc(1, 0, 0, 0); k++; end
        while (n_pay < 39 && k < 300) begin cyc(1, 0, 0, 0); k++; end
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("cut_payload_syms", n_pay, 40);
        chk("cut_frame_dones", n_fd, 1);
        chk("cut_state", int'(state), 1);

        // Wide window: no alignment, then abort in HEADER.
        t_mode = 4'b0001; t_win = 8'd40;
        wait_state(2, 0);
        cyc(0, 1, 0, 0);
        wait_state(3, 0);
        n_fs = 0; n_fd = 0;
        t_sgn = 1'b1;
        cyc(0, 0, 1, 0);
        t_sgn = 1'b0;
        cyc(0, 0, 0, 0);
        chk("wide_align_state", int'(state), 4);
        cyc(0, 0, 0, 0);
        chk("wide_hdr_state", int'(state), 5);
        chk("wide_frame_starts", n_fs, 1);
        repeat (4) cyc(1, 0, 0, 0);
        t_mode = 4'b0000;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("abort_state", int'(state), 0);
        chk("abort_frame_dones", n_fd, 0);
        chk("abort_depack", int'(depack_en), 0);
        chk("abort_flip", int'(phase_flip), 0);

        // Reset held for three clocks in the middle of a payload.
        t_mode = 4'b0001; t_win = 8'd8;
        wait_state(2, 0);
        cyc(0, 1, 0, 0);
        wait_state(3, 0);
        t_sgn = 1'b1;
        cyc(0, 0, 1, 0);
        t_sgn = 1'b0;
        wait_state(6, 1);
        repeat (5) cyc(1, 0, 0, 0);
        t_rst = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({PD_en, BD_en, depack_en, is_bpsk,
            phase_flip, frame_start, frame_done, timeout}), 0);
        t_rst = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("post_rst_state", int'(state), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
